// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus, beside dmem.
// Latency: a byte stored at edge N is popped at edge N+1 (txd falls after it); a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none on the bus; a store to a full FIFO with no same-cycle pop is dropped and sets sticky overflow.
//
// Ports:
//   clk      block clock (same clock as dmem)
//   reset    asynchronous, active-high; clears FIFO, FSM, counters and overflow
//   daddr    CPU data byte address
//   dwdata   CPU store data; TXDATA takes [7:0], STATUS write uses bit 3 (clear overflow)
//   we       per-byte write enables; only we[0] is honoured
//   drdata   combinational read data, zero when not selected or when TXDATA is addressed
//   sel      combinational decode of the 8-byte register window at BASE_ADDR
//   txd      serial output, idles high
//   tx_busy  high while a frame is on the line or bytes are still queued
//
// Register map (daddr[1:0] ignored):
//   +0 TXDATA  write pushes dwdata[7:0]; reads return 0
//   +4 STATUS  {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic        sel,
  output logic        txd,
  output logic        tx_busy
);

  // FIFO pointers are log2(depth) bits so they wrap for free; the count
  // needs one more bit to represent the completely full case.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic txdata_wr;
  logic status_wr;

  assign sel       = (daddr[31:3] == BASE_ADDR[31:3]);
  assign txdata_wr = sel & ~daddr[2] & we[0];
  assign status_wr = sel &  daddr[2] & we[0];

  // Bits of the bus this block deliberately ignores.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{daddr[1:0], dwdata[31:8], we[3:1]};

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];

  // A store while full still fits when the serialiser frees a slot on the
  // same edge; the count then stays at FIFO_DEPTH.
  assign push = txdata_wr & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dwdata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------------
  logic overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (status_wr & dwdata[3]) begin
      // Clear has priority over a set.
      overflow <= 1'b0;
    end else if (txdata_wr & ~push) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_d;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_d;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_d;
  logic          txd_q;
  logic          txd_d;
  logic          baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      txd_q     <= 1'b1;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_d;
      bit_idx   <= bit_d;
      shift_reg <= shift_d;
      txd_q     <= txd_d;
    end
  end

  // txd is registered one stage ahead: each branch sets the level that the
  // line must carry during the state being entered.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift_reg;
    txd_d   = txd_q;
    pop     = 1'b0;

    case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          txd_d   = 1'b0;
          baud_d  = '0;
        end
      end

      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shift_reg[0];
          baud_d  = '0;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // Shift right and present the next bit (LSB first).
            bit_d   = bit_idx + 3'd1;
            shift_d = {1'b0, shift_reg[7:1]};
            txd_d   = shift_reg[1];
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            // Chain straight into the next start bit: no idle gap between frames.
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs and read path
  // ---------------------------------------------------------------------------
  logic        fsm_busy;
  logic [7:0]  count8;
  logic [31:0] status_word;

  assign fsm_busy    = (state != IDLE);
  assign count8      = 8'(count);
  assign status_word = {16'h0000, count8, 4'h0, overflow, fsm_busy, empty, full};

  assign drdata  = (sel & daddr[2]) ? status_word : 32'h0000_0000;
  assign txd     = txd_q;
  assign tx_busy = fsm_busy | ~empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with a frame-decoding monitor.
// Stimulus pushes {byte, expected start edge} into a queue; the monitor decodes txd and pops/compares.
// Register reads are compared against hand-computed STATUS words.

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic        sel;
  logic        txd;
  logic        tx_busy;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .daddr  (daddr),
    .dwdata (dwdata),
    .we     (we),
    .drdata (drdata),
    .sel    (sel),
    .txd    (txd),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int frames_seen = 0;

  typedef struct {
    logic [7:0] d;
    int         start;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, want);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int start);
    exp_t e;
    e.d = d;
    e.start = start;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; the store lands on the next posedge, whose number is returned.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                           output int n);
    daddr  = a;
    dwdata = d;
    we     = w;
    @(posedge clk);
    @(negedge clk);
    n      = edge_no;
    daddr  = '0;
    dwdata = '0;
    we     = '0;
  endtask

  task automatic check_status(input string name, input logic [31:0] want);
    daddr = BASE + 32'd4;
    we    = '0;
    #1;
    check(name, drdata, want);
    daddr = '0;
  endtask

  task automatic sel_probe(input string name, input logic [31:0] a, input logic want_sel,
                           input logic [31:0] want_rd);
    daddr = a;
    we    = '0;
    #1;
    check({name, "_sel"}, sel, want_sel);
    check({name, "_rd"}, drdata, want_rd);
    daddr = '0;
  endtask

  task automatic wait_edge(input int target);
    while (edge_no < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) begin
        at = edge_no;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: 40 samples per frame at CLKS_PER_BIT=4, one per negedge.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [39:0] s;
    logic [7:0]  d;
    int          start;
    bit          aborted;
    bit          ok;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && txd === 1'b0) begin
        start   = edge_no;
        s       = '0;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          s[i] = txd;
        end
        if (!aborted) begin
          ok = 1'b1;
          for (int b = 0; b < 10; b++) begin
            for (int j = 1; j < 4; j++) begin
              if (s[4*b+j] !== s[4*b]) ok = 1'b0;
            end
          end
          if (s[0] !== 1'b0 || s[36] !== 1'b1) ok = 1'b0;
          for (int b = 0; b < 8; b++) d[b] = s[4 + 4*b];
          frames_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got byte 0x%02h starting at edge %0d, required no frame",
                     d, start);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", {24'h0, d}, {24'h0, e.d});
            check("frame_start_edge", start, e.start);
            check("frame_shape", {31'h0, ok}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int         n;
    int         m;
    int         t;
    logic [7:0] ov_b [6];

    daddr  = '0;
    dwdata = '0;
    we     = '0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 32'd1);
    check("reset_busy", tx_busy, 32'd0);
    check_status("reset_status", 32'h0000_0002);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: 0x55 with junk in the upper data bytes.
    bus_write(BASE, 32'hABCD_EF55, 4'b0001, n);
    expect_frame(8'h55, n + 1);
    check("t1_busy_queued", tx_busy, 32'd1);
    check_status("t1_status_queued", 32'h0000_0100);
    @(negedge clk);
    check_status("t1_status_popped", 32'h0000_0006);
    wait_edge(n + 40);
    check("t1_busy_last_stop", tx_busy, 32'd1);
    @(negedge clk);
    check("t1_busy_fall", tx_busy, 32'd0);
    check_status("t1_status_done", 32'h0000_0002);

    // Back-to-back frames.
    repeat (2) @(negedge clk);
    bus_write(BASE, 32'h0000_00A5, 4'b0001, n);
    expect_frame(8'hA5, n + 1);
    bus_write(BASE, 32'h0000_003C, 4'b0001, m);
    expect_frame(8'h3C, n + 41);
    @(negedge clk);
    check_status("t2_count_in_frame1", 32'h0000_0104);
    wait_idle(200, t);
    check("t2_end_edge", t, n + 81);
    check_status("t2_status_done", 32'h0000_0002);

    // Overflow with depth 4: six stores, the sixth is dropped.
    repeat (2) @(negedge clk);
    ov_b[0] = 8'h01; ov_b[1] = 8'h80; ov_b[2] = 8'hF0;
    ov_b[3] = 8'h0F; ov_b[4] = 8'hC3; ov_b[5] = 8'h99;
    m = 0;
    for (int i = 0; i < 6; i++) begin
      bus_write(BASE, {24'h0, ov_b[i]}, 4'b0001, n);
      if (i == 0) m = n;
      if (i < 5) expect_frame(ov_b[i], m + 1 + 40*i);
    end
    check_status("t3_overflow_set", 32'h0000_040D);
    bus_write(BASE + 32'd4, 32'h0000_0008, 4'b0001, n);
    check_status("t3_overflow_cleared", 32'h0000_0405);
    // Store into the full FIFO on the very edge the second frame is popped.
    wait_edge(m + 40);
    bus_write(BASE, 32'h0000_005A, 4'b0001, n);
    expect_frame(8'h5A, m + 201);
    check_status("t3_push_at_pop", 32'h0000_0405);
    wait_idle(400, t);
    check("t3_end_edge", t, m + 241);
    check_status("t3_status_done", 32'h0000_0002);

    // Address decode: none of these may push.
    @(negedge clk);
    sel_probe("t4_plus8", BASE + 32'd8, 1'b0, 32'h0);
    sel_probe("t4_minus4", 32'hFFFE_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    sel_probe("t4_status_alias", BASE + 32'd7, 1'b1, 32'h0000_0002);
    sel_probe("t4_txdata_read", BASE + 32'd3, 1'b1, 32'h0);
    @(negedge clk);
    bus_write(BASE + 32'd8, 32'h0000_0077, 4'b0001, n);
    bus_write(BASE, 32'h0000_0066, 4'b0010, n);
    bus_write(BASE, 32'h0000_0044, 4'b1110, n);
    bus_write(BASE + 32'd4, 32'h0000_0055, 4'b0001, n);
    check_status("t4_no_push", 32'h0000_0002);
    check("t4_busy", tx_busy, 32'd0);

    // Read path with bytes queued, then reset in the middle of DATA bit 3.
    repeat (20) @(negedge clk);
    bus_write(BASE, 32'h0000_0011, 4'b0001, n);
    bus_write(BASE, 32'h0000_0022, 4'b0001, m);
    bus_write(BASE, 32'h0000_0033, 4'b0001, m);
    check_status("t5_status_queued", 32'h0000_0204);
    sel_probe("t5_txdata_read", BASE, 1'b1, 32'h0);
    wait_edge(n + 18);
    check("t5_txd_bit3", txd, 32'd0);
    reset = 1'b1;
    #1;
    check("t5_txd_async", txd, 32'd1);
    check("t5_busy_in_reset", tx_busy, 32'd0);
    check_status("t5_status_in_reset", 32'h0000_0002);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_status("t5_status_after", 32'h0000_0002);
    repeat (60) @(negedge clk);
    check("t5_busy_quiet", tx_busy, 32'd0);
    check("t5_txd_idle", txd, 32'd1);

    check("frames_seen", frames_seen, 32'd9);
    check("exp_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
